// File: rtl/servo_pkg.sv
// Shared defaults and state encoding for the servo PWM path.
// Build option: PWM_DIR_DEADTIME_EN adds the DEAD state.
package servo_pkg;

  localparam int DEF_DATA_W = 18;
  localparam int DEF_CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_t;

endpackage

// File: rtl/pwm_duty_scale.sv
// Maps a signed IPD word to direction plus clamped PWM duty.
// Most-negative input is folded onto the most-positive magnitude.
module pwm_duty_scale
  import servo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SHIFT    = 7,
  parameter int MAX_DUTY = 950
) (
  input  logic [DATA_W-1:0] IPD,
  output logic [CNT_W-1:0]  d,
  output logic              dir,
  output logic              sat
);

  localparam logic [DATA_W-1:0] MAXD =
    DATA_W'(MAX_DUTY);
  localparam logic [DATA_W-1:0] MOST_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] scaled;

  always_comb begin
    dir = IPD[DATA_W-1];
    mag = IPD;
    if (dir) begin
      mag = (IPD == MOST_NEG) ? ~MOST_NEG
                              : (~IPD + 1'b1);
    end
    scaled = mag >> SHIFT;
    sat    = scaled > MAXD;
    d      = sat ? CNT_W'(MAX_DUTY)
                 : CNT_W'(scaled);
  end

endmodule

// File: rtl/ipd_pwm_driver.sv
// Plant-side I_PD interface: sample strobe, IPD capture, sign/mag PWM.
// Build option: PWM_DIR_DEADTIME_EN inserts a dead period on reversal.
module ipd_pwm_driver
  import servo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERIOD    = 1000,
  parameter int SHIFT     = 7,
  parameter int MAX_DUTY  = 950,
  parameter int LATCH_DLY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_motor,
  input  logic signed [DATA_W-1:0] IPD,
  output logic                     enable,
  output logic                     pwm,
  output logic                     dir,
  output logic [CNT_W-1:0]         duty,
  output logic                     sat
);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD-1);
  localparam logic [CNT_W-1:0] LATCH = CNT_W'(LATCH_DLY);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] sh_duty, sh_duty_n;
  logic             sh_dir, sh_dir_n;
  logic             sh_sat, sh_sat_n;
  logic [CNT_W-1:0] duty_n;
  logic             dir_n, sat_n;
  logic             enable_n, pwm_n;
  logic [CNT_W-1:0] sc_d;
  logic             sc_dir, sc_sat;

  pwm_duty_scale #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .SHIFT    (SHIFT),
    .MAX_DUTY (MAX_DUTY)
  ) u_scale (
    .IPD (IPD),
    .d   (sc_d),
    .dir (sc_dir),
    .sat (sc_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sh_duty <= '0;
      sh_dir  <= 1'b0;
      sh_sat  <= 1'b0;
      duty    <= '0;
      dir     <= 1'b0;
      sat     <= 1'b0;
      enable  <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh_duty <= sh_duty_n;
      sh_dir  <= sh_dir_n;
      sh_sat  <= sh_sat_n;
      duty    <= duty_n;
      dir     <= dir_n;
      sat     <= sat_n;
      enable  <= enable_n;
      pwm     <= pwm_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_duty_n = sh_duty;
    sh_dir_n  = sh_dir;
    sh_sat_n  = sh_sat;
    duty_n    = duty;
    dir_n     = dir;
    sat_n     = sat;
    unique case (state)
      IDLE: begin
        if (en_motor) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      default: begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LATCH) begin
          sh_duty_n = sc_d;
          sh_dir_n  = sc_dir;
          sh_sat_n  = sc_sat;
        end
        if (cnt == LAST) begin
          state_n = RUN;
          duty_n  = sh_duty;
          dir_n   = sh_dir;
          sat_n   = sh_sat;
`ifdef PWM_DIR_DEADTIME_EN
          // Reversal under load: idle the bridge for one period.
          if (state == RUN && sh_dir != dir
              && duty != '0) begin
            state_n = DEAD;
            duty_n  = '0;
            dir_n   = dir;
            sat_n   = 1'b0;
          end
`endif
        end
        if (!en_motor) begin
          state_n   = IDLE;
          cnt_n     = '0;
          sh_duty_n = '0;
          sh_dir_n  = 1'b0;
          sh_sat_n  = 1'b0;
          duty_n    = '0;
          dir_n     = 1'b0;
          sat_n     = 1'b0;
        end
      end
    endcase
    // Outputs are registered against the upcoming count.
    enable_n = (state_n != IDLE) && (cnt_n == '0);
    pwm_n    = (state_n != IDLE) && (cnt_n < duty_n);
  end

endmodule

// File: tb/tb_ipd_pwm_driver.sv
// Scoreboard bench for ipd_pwm_driver with a per-period reference model.
// Honours PWM_DIR_DEADTIME_EN in the model when defined.
module tb_ipd_pwm_driver;

  localparam int PER = 100;
  localparam int N   = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              en_motor;
  logic signed [17:0] IPD;
  logic              enable, pwm, dir, sat;
  logic [9:0]        duty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int duty;
    bit dir;
    bit sat;
  } exp_t;

  exp_t q[$];
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  ipd_pwm_driver #(
    .DATA_W    (18),
    .CNT_W     (10),
    .PERIOD    (PER),
    .SHIFT     (4),
    .MAX_DUTY  (95),
    .LATCH_DLY (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en_motor (en_motor),
    .IPD      (IPD),
    .enable   (enable),
    .pwm      (pwm),
    .dir      (dir),
    .duty     (duty),
    .sat      (sat)
  );

  function automatic exp_t model(int x);
    exp_t e;
    int   mag;
    mag = (x < 0) ? -x : x;
    if (mag > 131071) mag = 131071;
    mag    = mag / 16;
    e.dir  = (x < 0);
    e.sat  = (mag > 95);
    e.duty = e.sat ? 95 : mag;
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_enable(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3*PER; i++) begin
      @(negedge clk);
      if (enable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("enable_timeout", 0, 1);
  endtask

  // Monitor: one expected record per enable pulse.
  int   k = 0;
  bit   have = 1'b0;
  bit   bad = 1'b0;
  exp_t cur = '{0, 1'b0, 1'b0};

  always @(negedge clk) begin
    if (mon_on) begin
      if (enable) begin
        if (have) begin
          check("period_len", k, PER);
          check("pwm_shape", int'(bad), 0);
        end
        if (q.size() == 0) begin
          check("queue_underrun", 1, 0);
        end else begin
          cur = q.pop_front();
          check("duty", int'(duty), cur.duty);
          check("dir", int'(dir), int'(cur.dir));
          check("sat", int'(sat), int'(cur.sat));
        end
        have = 1'b1;
        k    = 0;
        bad  = 1'b0;
      end
      if (have && (pwm != (k < cur.duty))) bad = 1'b1;
      k++;
    end
  end

  initial begin
    int   vals[N];
    exp_t applied, sh;
    bit   ok, dead;
    int   hi;

    vals[0] = 800;
    vals[1] = 800;
    vals[2] = -320;
    vals[3] = 131071;
    vals[4] = -131072;
    vals[5] = -800;
    vals[6] = 800;
    vals[7] = 0;
    for (int i = 8; i < N-2; i++) begin
      if (i % 2 == 0)
        vals[i] = int'($urandom_range(4000)) - 2000;
      else
        vals[i] = int'($urandom_range(262143)) - 131072;
    end
    vals[N-2] = 800;
    vals[N-1] = 800;

    reset    = 1'b1;
    en_motor = 1'b1;
    IPD      = 18'sd800;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            int'({enable, pwm, dir, sat, duty}), 0);
    end

    applied = '{0, 1'b0, 1'b0};
    dead    = 1'b0;
    q.push_back(applied);
    mon_on = 1'b1;
    reset  = 1'b0;

    for (int p = 0; p < N; p++) begin
      wait_enable(ok);
      IPD = 18'(vals[p]);
      sh  = model(vals[p]);
`ifdef PWM_DIR_DEADTIME_EN
      if (dead) begin
        dead    = 1'b0;
        applied = sh;
      end else if (sh.dir != applied.dir && applied.duty != 0) begin
        dead         = 1'b1;
        applied.duty = 0;
        applied.sat  = 1'b0;
      end else begin
        applied = sh;
      end
`else
      applied = sh;
`endif
      q.push_back(applied);
    end

    wait_enable(ok);
    @(negedge clk);
    mon_on = 1'b0;
    check("queue_empty", q.size(), 0);

    // Drop en_motor mid-period with duty 50 applied.
    wait_enable(ok);
    repeat (30) @(negedge clk);
    check("drop_pwm_before", int'(pwm), 1);
    check("drop_duty_before", int'(duty), 50);
    en_motor = 1'b0;
    @(negedge clk);
    check("drop_outputs",
          int'({enable, pwm, dir, sat, duty}), 0);
    repeat (5) @(negedge clk);
    check("idle_outputs",
          int'({enable, pwm, dir, sat, duty}), 0);

    en_motor = 1'b1;
    @(negedge clk);
    check("reen_enable", int'(enable), 1);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk);
      hi += int'(pwm);
    end
    check("reen_first_period_pwm", hi, 0);
    @(negedge clk);
    check("reen_enable2", int'(enable), 1);
    check("reen_duty", int'(duty), 50);
    check("reen_pwm", int'(pwm), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
